// File: rtl/ps2_pkg.sv
// Shared constants and state encoding for the PS/2 scan-code decoder.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    // Bytes following E1 that belong to the Pause sequence.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        DECODE = 2'd2
    } state_t;

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational set-2 scan code to ASCII lookup; unmapped codes give 0x00.
module ps2_scan_to_ascii (
    input  logic [7:0] i_code,
    input  logic       i_shift,
    input  logic       i_caps,
    output logic [7:0] o_ascii
);

    logic [7:0] w_base;
    logic [7:0] w_shifted;
    logic       w_letter;

    always_comb begin
        w_base    = 8'h00;
        w_shifted = 8'h00;
        unique case (i_code)
            8'h1C: w_base = "a";
            8'h32: w_base = "b";
            8'h21: w_base = "c";
            8'h23: w_base = "d";
            8'h24: w_base = "e";
            8'h2B: w_base = "f";
            8'h34: w_base = "g";
            8'h33: w_base = "h";
            8'h43: w_base = "i";
            8'h3B: w_base = "j";
            8'h42: w_base = "k";
            8'h4B: w_base = "l";
            8'h3A: w_base = "m";
            8'h31: w_base = "n";
            8'h44: w_base = "o";
            8'h4D: w_base = "p";
            8'h15: w_base = "q";
            8'h2D: w_base = "r";
            8'h1B: w_base = "s";
            8'h2C: w_base = "t";
            8'h3C: w_base = "u";
            8'h2A: w_base = "v";
            8'h1D: w_base = "w";
            8'h22: w_base = "x";
            8'h35: w_base = "y";
            8'h1A: w_base = "z";
            8'h16: begin w_base = "1";  w_shifted = "!"; end
            8'h1E: begin w_base = "2";  w_shifted = "@"; end
            8'h26: begin w_base = "3";  w_shifted = "#"; end
            8'h25: begin w_base = "4";  w_shifted = "$"; end
            8'h2E: begin w_base = "5";  w_shifted = "%"; end
            8'h36: begin w_base = "6";  w_shifted = "^"; end
            8'h3D: begin w_base = "7";  w_shifted = "&"; end
            8'h3E: begin w_base = "8";  w_shifted = "*"; end
            8'h46: begin w_base = "9";  w_shifted = "("; end
            8'h45: begin w_base = "0";  w_shifted = ")"; end
            8'h0E: begin w_base = 8'h60; w_shifted = "~"; end
            8'h4E: begin w_base = "-";  w_shifted = "_"; end
            8'h55: begin w_base = "=";  w_shifted = "+"; end
            8'h54: begin w_base = "[";  w_shifted = "{"; end
            8'h5B: begin w_base = "]";  w_shifted = "}"; end
            8'h5D: begin w_base = "\\"; w_shifted = "|"; end
            8'h4C: begin w_base = ";";  w_shifted = ":"; end
            8'h52: begin w_base = "'";  w_shifted = "\""; end
            8'h41: begin w_base = ",";  w_shifted = "<"; end
            8'h49: begin w_base = ".";  w_shifted = ">"; end
            8'h4A: begin w_base = "/";  w_shifted = "?"; end
            8'h29: begin w_base = 8'h20; w_shifted = 8'h20; end
            8'h5A: begin w_base = 8'h0D; w_shifted = 8'h0D; end
            8'h66: begin w_base = 8'h08; w_shifted = 8'h08; end
            8'h0D: begin w_base = 8'h09; w_shifted = 8'h09; end
            8'h76: begin w_base = 8'h1B; w_shifted = 8'h1B; end
            default: begin w_base = 8'h00; w_shifted = 8'h00; end
        endcase
    end

    // Letters follow shift XOR caps; everything else only follows shift.
    assign w_letter = (w_base >= "a") && (w_base <= "z");

    always_comb begin
        o_ascii = w_base;
        if (w_letter) begin
            if (i_shift ^ i_caps) begin
                o_ascii = w_base - 8'h20;
            end
        end else if (i_shift) begin
            o_ascii = w_shifted;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Pops PS/2 scan-code bytes from the receiver FIFO and turns E0/F0 prefixed
// sequences into single key events with shift/caps/held/typematic tracking.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_kbd_data,
    input  logic             i_kbd_ready,
    output logic             o_kbd_nextdata_n,
    input  logic             i_kbd_overflow,
    output logic             o_ev_valid,
    output logic [7:0]       o_ev_code,
    output logic             o_ev_ext,
    output logic             o_ev_release,
    output logic             o_ev_repeat,
    output logic [7:0]       o_ev_ascii,
    output logic             o_key_held,
    output logic             o_caps_on,
    output logic [CNT_W-1:0] o_press_cnt,
    output logic             o_err
);

    state_t           r_state;
    state_t           w_nextState;
    logic [7:0]       r_byte;
    logic             r_nextdataN;

    logic             r_extPend;
    logic             r_brkPend;
    logic             r_shiftL;
    logic             r_shiftR;
    logic [2:0]       r_skipCnt;
    logic [7:0]       r_heldCode;
    logic             r_heldExt;
    logic             r_keyHeld;
    logic             r_capsOn;
    logic [CNT_W-1:0] r_pressCnt;
    logic             r_err;
    logic             r_ovfPrev;

    logic             r_evValid;
    logic [7:0]       r_evCode;
    logic             r_evExt;
    logic             r_evRelease;
    logic             r_evRepeat;
    logic [7:0]       r_evAscii;

    logic [7:0]       w_ascii;
    logic             w_pairMatch;
    logic             w_repeat;
    logic             w_isErrByte;
    logic             w_batIgnore;
    logic             w_emit;

    ps2_scan_to_ascii u_ascii (
        .i_code  (r_byte),
        .i_shift (r_shiftL | r_shiftR),
        .i_caps  (r_capsOn),
        .o_ascii (w_ascii)
    );

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (i_kbd_ready) w_nextState = POP;
            POP:     w_nextState = DECODE;
            DECODE:  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Pop strobe is registered so it is low for exactly the POP cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_byte      <= 8'h00;
            r_nextdataN <= 1'b1;
        end else begin
            r_state     <= w_nextState;
            r_nextdataN <= (w_nextState != POP);
            if (r_state == IDLE && i_kbd_ready) begin
                r_byte <= i_kbd_data;
            end
        end
    end

    assign w_pairMatch = (r_byte == r_heldCode) && (r_extPend == r_heldExt);
    assign w_repeat    = r_keyHeld && w_pairMatch;
    assign w_isErrByte = (r_byte == SC_ERR0) || (r_byte == SC_ERR1);
    assign w_batIgnore = (r_byte == SC_BAT) && !r_extPend && !r_brkPend;
    assign w_emit      = (r_skipCnt == 3'd0) && (r_byte != SC_PAUSE) && !w_isErrByte
                         && (r_byte != SC_EXT) && (r_byte != SC_BRK) && !w_batIgnore;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_extPend   <= 1'b0;
            r_brkPend   <= 1'b0;
            r_shiftL    <= 1'b0;
            r_shiftR    <= 1'b0;
            r_skipCnt   <= 3'd0;
            r_heldCode  <= 8'h00;
            r_heldExt   <= 1'b0;
            r_keyHeld   <= 1'b0;
            r_capsOn    <= 1'b0;
            r_pressCnt  <= '0;
            r_err       <= 1'b0;
            r_ovfPrev   <= 1'b0;
            r_evValid   <= 1'b0;
            r_evCode    <= 8'h00;
            r_evExt     <= 1'b0;
            r_evRelease <= 1'b0;
            r_evRepeat  <= 1'b0;
            r_evAscii   <= 8'h00;
        end else begin
            r_evValid <= 1'b0;
            r_ovfPrev <= i_kbd_overflow;
            r_err     <= i_kbd_overflow && !r_ovfPrev;
            if (r_state == DECODE) begin
                if (r_skipCnt != 3'd0) begin
                    r_skipCnt <= r_skipCnt - 3'd1;
                end else if (r_byte == SC_PAUSE) begin
                    r_skipCnt <= PAUSE_SKIP;
                    r_extPend <= 1'b0;
                    r_brkPend <= 1'b0;
                end else if (w_isErrByte) begin
                    r_err     <= 1'b1;
                    r_extPend <= 1'b0;
                    r_brkPend <= 1'b0;
                end else if (r_byte == SC_EXT) begin
                    r_extPend <= 1'b1;
                end else if (r_byte == SC_BRK) begin
                    r_brkPend <= 1'b1;
                end else if (w_emit) begin
                    r_evValid   <= 1'b1;
                    r_evCode    <= r_byte;
                    r_evExt     <= r_extPend;
                    r_evRelease <= r_brkPend;
                    r_evRepeat  <= !r_brkPend && w_repeat;
                    r_evAscii   <= (r_extPend || r_brkPend) ? 8'h00 : w_ascii;
                    r_extPend   <= 1'b0;
                    r_brkPend   <= 1'b0;
                    if (!r_brkPend) begin
                        if (!w_repeat) begin
                            r_heldCode <= r_byte;
                            r_heldExt  <= r_extPend;
                            r_keyHeld  <= 1'b1;
                            r_pressCnt <= r_pressCnt + {{(CNT_W-1){1'b0}}, 1'b1};
                            if (r_byte == SC_CAPS && !r_extPend) begin
                                r_capsOn <= !r_capsOn;
                            end
                        end
                    end else if (w_pairMatch) begin
                        r_keyHeld <= 1'b0;
                    end
                    // Shift state is tracked regardless of which key is held.
                    if (!r_extPend) begin
                        if (r_byte == SC_LSHIFT) r_shiftL <= !r_brkPend;
                        if (r_byte == SC_RSHIFT) r_shiftR <= !r_brkPend;
                    end
                end
            end
        end
    end

    assign o_kbd_nextdata_n = r_nextdataN;
    assign o_ev_valid       = r_evValid;
    assign o_ev_code        = r_evCode;
    assign o_ev_ext         = r_evExt;
    assign o_ev_release     = r_evRelease;
    assign o_ev_repeat      = r_evRepeat;
    assign o_ev_ascii       = r_evAscii;
    assign o_key_held       = r_keyHeld;
    assign o_caps_on        = r_capsOn;
    assign o_press_cnt      = r_pressCnt;
    assign o_err            = r_err;

endmodule
